ex_mem_stage: RTL and testbench

//  EX/MEM pipeline stage directly downstream of the 64-bit ALU. Captures ALU Result/ZERO,

---
 rtl/ex_mem_pkg.sv | 23 ++
 rtl/pipe_skid_buffer.sv | 70 +++++++
 rtl/ex_mem_stage.sv | 79 +++++++
 tb/tb_ex_mem_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline stage: control-bit positions and packed payload layout.
package ex_mem_pkg;
   localparam int DEF_XLEN       = 64;
   localparam int DEF_REG_ADDR_W = 5;

   localparam int CTRL_BRANCH   = 4;
   localparam int CTRL_MEMREAD  = 3;
   localparam int CTRL_MEMWRITE = 2;
   localparam int CTRL_REGWRITE = 1;
   localparam int CTRL_MEMTOREG = 0;
   localparam int CTRL_W        = 5;

   typedef struct packed {
      logic [DEF_XLEN-1:0]       result;
      logic                      zero;
      logic [DEF_XLEN-1:0]       store_data;
      logic [DEF_XLEN-1:0]       br_target;
      logic [DEF_REG_ADDR_W-1:0] rd;
      logic [CTRL_W-1:0]         ctrl;
   } ex_mem_payload_t;

   localparam int PAYLOAD_W = $bits(ex_mem_payload_t);
endpackage

// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready skid buffer on an opaque packed payload; main entry drives the output,
// skid entry absorbs one beat of backpressure so in_ready can be a plain register.
module pipe_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);
   logic             main_valid_q, main_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] main_data_q, main_data_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             accept;

   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_data_d  = main_data_q;
      skid_data_d  = skid_data_q;
      accept       = in_valid & ~skid_valid_q;

      // The skid entry is only ever occupied while main is occupied, so main-empty implies skid-empty.
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q) begin
         if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
         end
      end else if (out_ready) begin
         if (skid_valid_q) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_data_d  = in_data;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_data_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_data_q  <= main_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

   assign in_ready  = ~skid_valid_q;
   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;
endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: buffers ALU results toward MEM and resolves pc_src from the registered ZERO.
// Optional EX_MEM_STALL_CNT_EN adds a saturating stall_count of cycles the head entry waits on MEM.
module ex_mem_stage
   import ex_mem_pkg::*;
#(
   parameter int XLEN       = 64,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [XLEN-1:0]       in_result,
   input  logic                  in_zero,
   input  logic [XLEN-1:0]       in_store_data,
   input  logic [XLEN-1:0]       in_br_target,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic [CTRL_W-1:0]     in_ctrl,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_result,
   output logic                  out_zero,
   output logic [XLEN-1:0]       out_store_data,
   output logic [XLEN-1:0]       out_br_target,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic [CTRL_W-1:0]     out_ctrl,
   output logic                  pc_src
`ifdef EX_MEM_STALL_CNT_EN
   ,output logic [31:0]          stall_count
`endif
);
   // Payload width follows the package layout, rescaled when XLEN/REG_ADDR_W differ from the defaults.
   localparam int PW = PAYLOAD_W + 3 * (XLEN - DEF_XLEN) + (REG_ADDR_W - DEF_REG_ADDR_W);

   logic [PW-1:0] in_pay;
   logic [PW-1:0] out_pay;

   assign in_pay = {in_result, in_zero, in_store_data, in_br_target, in_rd, in_ctrl};

   pipe_skid_buffer #(
      .WIDTH (PW)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_pay),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_pay)
   );

   assign {out_result, out_zero, out_store_data, out_br_target, out_rd, out_ctrl} = out_pay;

   assign pc_src = out_valid & out_ctrl[CTRL_BRANCH] & out_zero;

`ifdef EX_MEM_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: vector table for streaming/branch/control pass-through,
// hand sequences for reset, backpressure, flush and (with EX_MEM_STALL_CNT_EN) the stall counter.
module tb_ex_mem_stage;
   import ex_mem_pkg::*;

   localparam logic [4:0] C_BR  = 5'(1 << CTRL_BRANCH);
   localparam logic [4:0] C_MR  = 5'(1 << CTRL_MEMREAD);
   localparam logic [4:0] C_MW  = 5'(1 << CTRL_MEMWRITE);
   localparam logic [4:0] C_RW  = 5'(1 << CTRL_REGWRITE);
   localparam logic [4:0] C_M2R = 5'(1 << CTRL_MEMTOREG);

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_result;
   logic        in_zero;
   logic [63:0] in_store_data;
   logic [63:0] in_br_target;
   logic [4:0]  in_rd;
   logic [4:0]  in_ctrl;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;
   logic        out_zero;
   logic [63:0] out_store_data;
   logic [63:0] out_br_target;
   logic [4:0]  out_rd;
   logic [4:0]  out_ctrl;
   logic        pc_src;
`ifdef EX_MEM_STALL_CNT_EN
   logic [31:0] stall_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ex_mem_stage #(
      .XLEN       (64),
      .REG_ADDR_W (5)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_result      (in_result),
      .in_zero        (in_zero),
      .in_store_data  (in_store_data),
      .in_br_target   (in_br_target),
      .in_rd          (in_rd),
      .in_ctrl        (in_ctrl),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_result     (out_result),
      .out_zero       (out_zero),
      .out_store_data (out_store_data),
      .out_br_target  (out_br_target),
      .out_rd         (out_rd),
      .out_ctrl       (out_ctrl),
      .pc_src         (pc_src)
`ifdef EX_MEM_STALL_CNT_EN
      ,.stall_count   (stall_count)
`endif
   );

   typedef struct {
      logic            iv;
      logic            ordy;
      ex_mem_payload_t p;
      logic            e_ov;
      logic            e_ir;
      logic            e_pc;
      logic            chk_pay;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic put(input logic iv, input logic ordy, input logic fl,
                      input logic [63:0] res, input logic z, input logic [63:0] bt,
                      input logic [4:0] ctrl);
      in_valid      = iv;
      out_ready     = ordy;
      flush         = fl;
      in_result     = res;
      in_zero       = z;
      in_store_data = res ^ 64'hFFFF_0000;
      in_br_target  = bt;
      in_rd         = res[4:0];
      in_ctrl       = ctrl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic iv, input logic [63:0] res, input logic z,
                               input logic [63:0] bt, input logic [4:0] ctrl,
                               input logic e_ov, input logic e_pc);
      vec_t v;
      v.iv           = iv;
      v.ordy         = 1'b1;
      v.p.result     = res;
      v.p.zero       = z;
      v.p.store_data = 64'hA000 + res;
      v.p.br_target  = bt;
      v.p.rd         = res[4:0];
      v.p.ctrl       = ctrl;
      v.e_ov         = e_ov;
      v.e_ir         = 1'b1;
      v.e_pc         = e_pc;
      v.chk_pay      = e_ov;
      return v;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = mk(1'b1, 64'd1, 1'b0, 64'h0,    C_RW,               1'b1, 1'b0);
      vecs[1] = mk(1'b1, 64'd2, 1'b1, 64'h1000, C_BR,               1'b1, 1'b1);
      vecs[2] = mk(1'b1, 64'd3, 1'b0, 64'h1000, C_BR,               1'b1, 1'b0);
      vecs[3] = mk(1'b1, 64'd4, 1'b0, 64'h40,   C_MR | C_MW,        1'b1, 1'b0);
      vecs[4] = mk(1'b1, 64'd5, 1'b1, 64'h50,   C_MR | C_RW | C_M2R, 1'b1, 1'b0);
      vecs[5] = mk(1'b1, 64'd6, 1'b0, 64'h60,   C_MW,               1'b1, 1'b0);
      vecs[6] = mk(1'b1, 64'd7, 1'b1, 64'h2000, C_BR,               1'b1, 1'b1);
      vecs[7] = mk(1'b1, 64'd8, 1'b1, 64'h80,   C_RW,               1'b1, 1'b0);
      vecs[8] = mk(1'b0, 64'd9, 1'b1, 64'h90,   C_BR,               1'b0, 1'b0);

      // Reset held with valid input present
      reset = 1'b0;
      put(1'b1, 1'b1, 1'b0, 64'h99, 1'b1, 64'h1234, C_BR);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rst_out_valid", 64'(out_valid), 64'd0);
         chk("rst_in_ready",  64'(in_ready),  64'd1);
         chk("rst_pc_src",    64'(pc_src),    64'd0);
      end
      chk("rst_out_result", out_result, 64'd0);
      chk("rst_out_ctrl",   64'(out_ctrl), 64'd0);
`ifdef EX_MEM_STALL_CNT_EN
      chk("rst_stall_count", 64'(stall_count), 64'd0);
`endif
      put(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 5'd0);
      reset = 1'b1;
      tick();

      // Streaming and branch resolution from the vector table
      in_valid = vecs[0].iv;
      #1;
      chk("stream_pre_edge_valid", 64'(out_valid), 64'd0);
      for (int i = 0; i < 9; i++) begin
         in_valid      = vecs[i].iv;
         out_ready     = vecs[i].ordy;
         flush         = 1'b0;
         in_result     = vecs[i].p.result;
         in_zero       = vecs[i].p.zero;
         in_store_data = vecs[i].p.store_data;
         in_br_target  = vecs[i].p.br_target;
         in_rd         = vecs[i].p.rd;
         in_ctrl       = vecs[i].p.ctrl;
         tick();
         chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
         chk($sformatf("vec%0d_in_ready", i),  64'(in_ready),  64'(vecs[i].e_ir));
         chk($sformatf("vec%0d_pc_src", i),    64'(pc_src),    64'(vecs[i].e_pc));
         if (vecs[i].chk_pay) begin
            chk($sformatf("vec%0d_result", i),     out_result,          vecs[i].p.result);
            chk($sformatf("vec%0d_zero", i),       64'(out_zero),       64'(vecs[i].p.zero));
            chk($sformatf("vec%0d_store_data", i), out_store_data,      vecs[i].p.store_data);
            chk($sformatf("vec%0d_br_target", i),  out_br_target,       vecs[i].p.br_target);
            chk($sformatf("vec%0d_rd", i),         64'(out_rd),         64'(vecs[i].p.rd));
            chk($sformatf("vec%0d_ctrl", i),       64'(out_ctrl),       64'(vecs[i].p.ctrl));
         end
      end

      // Backpressure: A into main, B into skid, C blocked, then drain in order
      put(1'b1, 1'b0, 1'b0, 64'h11, 1'b0, 64'h0, C_RW);
      tick();
      chk("bp_a_valid",    64'(out_valid), 64'd1);
      chk("bp_a_result",   out_result,     64'h11);
      chk("bp_a_in_ready", 64'(in_ready),  64'd1);
      put(1'b1, 1'b0, 1'b0, 64'h22, 1'b0, 64'h0, C_RW);
      tick();
      chk("bp_b_in_ready", 64'(in_ready),  64'd0);
      chk("bp_b_result",   out_result,     64'h11);
      put(1'b1, 1'b0, 1'b0, 64'h33, 1'b0, 64'h0, C_RW);
      tick();
      chk("bp_hold_result",   out_result,    64'h11);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_rd",       64'(out_rd),   64'h11);
      put(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 5'd0);
      tick();
      chk("bp_drain1_valid",    64'(out_valid), 64'd1);
      chk("bp_drain1_result",   out_result,     64'h22);
      chk("bp_drain1_in_ready", 64'(in_ready),  64'd1);
      tick();
      chk("bp_drain2_valid",    64'(out_valid), 64'd0);

      // Flush with both entries full and a valid same-cycle input
      put(1'b1, 1'b0, 1'b0, 64'h44, 1'b1, 64'h1000, C_BR);
      tick();
      chk("fl_a_pc_src",    64'(pc_src),        64'd1);
      chk("fl_a_br_target", out_br_target,      64'h1000);
      put(1'b1, 1'b0, 1'b0, 64'h55, 1'b0, 64'h0, C_RW);
      tick();
      chk("fl_skid_full",   64'(in_ready),  64'd0);
      put(1'b1, 1'b0, 1'b1, 64'h66, 1'b0, 64'h0, C_RW);
      tick();
      chk("fl_out_valid",   64'(out_valid), 64'd0);
      chk("fl_in_ready",    64'(in_ready),  64'd1);
      chk("fl_pc_src",      64'(pc_src),    64'd0);
      put(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 5'd0);
      tick();
      chk("fl_after1_valid", 64'(out_valid), 64'd0);
      tick();
      chk("fl_after2_valid", 64'(out_valid), 64'd0);
      // Flush beats a same-cycle accept into an empty stage
      put(1'b1, 1'b1, 1'b1, 64'h88, 1'b0, 64'h0, C_RW);
      tick();
      chk("fl_empty_valid", 64'(out_valid), 64'd0);
      put(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 5'd0);
      tick();
      chk("fl_empty_after", 64'(out_valid), 64'd0);

`ifdef EX_MEM_STALL_CNT_EN
      // Stall counter: fresh reset, one accept, seven stalled cycles, flush while ready
      reset = 1'b0;
      #1;
      chk("sc_reset", 64'(stall_count), 64'd0);
      reset = 1'b1;
      tick();
      put(1'b1, 1'b0, 1'b0, 64'h77, 1'b0, 64'h0, C_RW);
      tick();
      chk("sc_after_accept", 64'(stall_count), 64'd0);
      put(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 5'd0);
      for (int i = 0; i < 7; i++) tick();
      chk("sc_seven",        64'(stall_count), 64'd7);
      chk("sc_held_result",  out_result,       64'h77);
      put(1'b0, 1'b1, 1'b1, 64'h0, 1'b0, 64'h0, 5'd0);
      tick();
      chk("sc_flush_keeps",  64'(stall_count), 64'd7);
      chk("sc_flush_valid",  64'(out_valid),   64'd0);
      put(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 5'd0);
      tick();
`endif

      // Asynchronous reset mid-transfer with both entries occupied
      put(1'b1, 1'b0, 1'b0, 64'hAA, 1'b1, 64'h3000, C_BR);
      tick();
      put(1'b1, 1'b0, 1'b0, 64'hBB, 1'b0, 64'h0, C_RW);
      tick();
      chk("mr_pre_in_ready", 64'(in_ready), 64'd0);
      #2;
      reset = 1'b0;
      #1;
      chk("mr_out_valid", 64'(out_valid), 64'd0);
      chk("mr_in_ready",  64'(in_ready),  64'd1);
      chk("mr_pc_src",    64'(pc_src),    64'd0);
      chk("mr_result",    out_result,     64'd0);
`ifdef EX_MEM_STALL_CNT_EN
      chk("mr_stall_count", 64'(stall_count), 64'd0);
`endif
      put(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 5'd0);
      tick();
      reset = 1'b1;
      tick();
      chk("mr_after_valid", 64'(out_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
